timer_sequencer: RTL and testbench

Run-control sequencer for the PWM/timer datapath, clocked on the selected timer clock. It owns the main up-counter and the start/stop/one-shot/continuous state machine. It latches the period safely, raises the sticky interrupt pending flag on period match and handles the interrupt clear. The bus-side control register drives its inputs, and its `cnt`/status outputs feed the compare/output logic and the control-register read-back.

---
 rtl/timer_sequencer.sv | 137 +++++++++++++
 tb/tb_timer_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/timer_sequencer.sv
// Run-control sequencer: owns the main up-counter, run/halt FSM, period shadow and sticky irq/err flags.
// Latency: start to RUN in one edge, wrap/irq_pend one edge after the terminal count; no backpressure, inputs are single-cycle pulses.
module timer_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             chosen_clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cont,
  input  logic             irq_en,
  input  logic             irq_clr,
  input  logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             wrap,
  output logic             irq_pend,
  output logic             irq,
  output logic [1:0]       state,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10,
    BAD  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic             mode_q, mode_d;
  logic             pend_q, pend_d;
  logic             err_q, err_d;
  logic             wrap_q, wrap_d;
  logic             busy_q;
  logic             match;
  logic             per_zero;

  assign match    = (state_q == RUN) && (cnt_q == per_q);
  assign per_zero = (period == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    per_d   = per_q;
    mode_d  = mode_q;
    pend_d  = pend_q;
    err_d   = err_q;
    wrap_d  = 1'b0;

    // Clear first so that a same-cycle set below takes priority.
    if (irq_clr) begin
      pend_d = 1'b0;
      err_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (per_zero) begin
            err_d = 1'b1;
          end else begin
            per_d   = period;
            mode_d  = cont;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (match) begin
          wrap_d = 1'b1;
          pend_d = 1'b1;
          if (stop) begin
            state_d = IDLE;
          end else if (mode_q) begin
            per_d = period;
          end else begin
            state_d = HALT;
          end
        end else if (stop) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      HALT: begin
        if (irq_clr) begin
          state_d = IDLE;
        end else if (start && !pend_q) begin
          if (per_zero) begin
            err_d = 1'b1;
          end else begin
            per_d   = period;
            mode_d  = cont;
            state_d = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge chosen_clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      mode_q  <= 1'b0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      wrap_q  <= wrap_d;
      busy_q  <= (state_d == RUN);
    end
  end

  assign cnt      = cnt_q;
  assign busy     = busy_q;
  assign wrap     = wrap_q;
  assign irq_pend = pend_q;
  assign irq      = pend_q & irq_en;
  assign state    = state_q;
  assign err      = err_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench for timer_sequencer with a 4-bit counter so the all-ones period stays short.
module tb_timer_sequencer;
  localparam int W = 4;

  logic         chosen_clk = 1'b0;
  logic         rst        = 1'b0;
  logic         start      = 1'b0;
  logic         stop       = 1'b0;
  logic         cont       = 1'b0;
  logic         irq_en     = 1'b0;
  logic         irq_clr    = 1'b0;
  logic [W-1:0] period     = '0;
  logic [W-1:0] cnt;
  logic         busy, wrap, irq_pend, irq, err;
  logic [1:0]   state;
  logic [6:0]   sts;

  int pass_cnt  = 0;
  int total_cnt = 0;

  timer_sequencer #(.CNT_W(W)) dut (
    .chosen_clk(chosen_clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .cont      (cont),
    .irq_en    (irq_en),
    .irq_clr   (irq_clr),
    .period    (period),
    .cnt       (cnt),
    .busy      (busy),
    .wrap      (wrap),
    .irq_pend  (irq_pend),
    .irq       (irq),
    .state     (state),
    .err       (err)
  );

  // Status vector: {state[1:0], busy, wrap, irq_pend, irq, err}
  assign sts = {state, busy, wrap, irq_pend, irq, err};

  always #5 chosen_clk = ~chosen_clk;

  task automatic tick();
    @(posedge chosen_clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; irq_en = 1'b1; period = 4'd5;
    #3;
    total_cnt++; if (cnt !== 4'd0) $display("FAIL reset_cnt: got %0d want 0", cnt); else pass_cnt++;
    total_cnt++; if (sts !== 7'b0000000) $display("FAIL reset_sts: got %b want 0000000", sts); else pass_cnt++;
    #10 rst = 1'b1;
    tick(); tick();
    total_cnt++; if (sts !== 7'b0000000 || cnt !== 4'd0) $display("FAIL reset_idle: sts %b cnt %0d want 0000000/0", sts, cnt); else pass_cnt++;
  endtask

  task automatic test_continuous();
    irq_en = 1'b0; period = 4'd4; cont = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    total_cnt++; if (sts !== 7'b0110000 || cnt !== 4'd0) $display("FAIL cont_start: sts %b cnt %0d want 0110000/0", sts, cnt); else pass_cnt++;
    for (int k = 1; k <= 12; k++) begin
      tick();
      total_cnt++; if (cnt !== W'(k % 5)) $display("FAIL cont_cnt k=%0d: got %0d want %0d", k, cnt, k % 5); else pass_cnt++;
      total_cnt++; if (wrap !== (k % 5 == 0)) $display("FAIL cont_wrap k=%0d: got %b want %b", k, wrap, (k % 5 == 0)); else pass_cnt++;
    end
    total_cnt++; if (sts !== 7'b0110100) $display("FAIL cont_pend_irq_off: got %b want 0110100", sts); else pass_cnt++;
    irq_en = 1'b1; #1;
    total_cnt++; if (irq !== 1'b1) $display("FAIL cont_irq_on: got %b want 1", irq); else pass_cnt++;
    stop = 1'b1; tick(); stop = 1'b0;
    total_cnt++; if (sts !== 7'b0000110 || cnt !== 4'd0) $display("FAIL cont_stop: sts %b cnt %0d want 0000110/0", sts, cnt); else pass_cnt++;
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    total_cnt++; if (sts !== 7'b0000000) $display("FAIL cont_clr: got %b want 0000000", sts); else pass_cnt++;
  endtask

  task automatic test_oneshot();
    period = 4'd3; cont = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      total_cnt++; if (cnt !== W'(k)) $display("FAIL oneshot_cnt k=%0d: got %0d want %0d", k, cnt, k); else pass_cnt++;
    end
    tick();
    total_cnt++; if (sts !== 7'b1001110 || cnt !== 4'd0) $display("FAIL oneshot_halt: sts %b cnt %0d want 1001110/0", sts, cnt); else pass_cnt++;
    start = 1'b1; tick(); start = 1'b0;
    total_cnt++; if (sts !== 7'b1000110 || cnt !== 4'd0) $display("FAIL oneshot_start_ignored: sts %b cnt %0d want 1000110/0", sts, cnt); else pass_cnt++;
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    total_cnt++; if (sts !== 7'b0000000) $display("FAIL oneshot_clr: got %b want 0000000", sts); else pass_cnt++;
  endtask

  task automatic test_period_change();
    int exp_cnt;
    period = 4'd6; cont = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    total_cnt++; if (cnt !== 4'd3) $display("FAIL perchg_cnt3: got %0d want 3", cnt); else pass_cnt++;
    period = 4'd2;
    for (int k = 4; k <= 11; k++) begin
      tick();
      exp_cnt = (k <= 6) ? k : (k - 7) % 3;
      total_cnt++; if (cnt !== W'(exp_cnt)) $display("FAIL perchg_cnt k=%0d: got %0d want %0d", k, cnt, exp_cnt); else pass_cnt++;
      total_cnt++; if (wrap !== (k == 7 || k == 10)) $display("FAIL perchg_wrap k=%0d: got %b want %b", k, wrap, (k == 7 || k == 10)); else pass_cnt++;
    end
    stop = 1'b1; tick(); stop = 1'b0;
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
  endtask

  task automatic test_collisions();
    period = 4'd2; cont = 1'b1; start = 1'b1; stop = 1'b1;
    tick(); start = 1'b0; stop = 1'b0;
    total_cnt++; if (sts !== 7'b0110000 || cnt !== 4'd0) $display("FAIL coll_idle_start_stop: sts %b cnt %0d want 0110000/0", sts, cnt); else pass_cnt++;
    tick(); tick();
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    total_cnt++; if (sts !== 7'b0111110 || cnt !== 4'd0) $display("FAIL coll_clr_on_match: sts %b cnt %0d want 0111110/0", sts, cnt); else pass_cnt++;
    tick();
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    total_cnt++; if (sts !== 7'b0110000 || cnt !== 4'd2) $display("FAIL coll_clr_plain: sts %b cnt %0d want 0110000/2", sts, cnt); else pass_cnt++;
    stop = 1'b1; tick(); stop = 1'b0;
    total_cnt++; if ({state, busy, irq_pend} !== 4'b0001 || cnt !== 4'd0) $display("FAIL coll_stop_on_match: st/busy/pend %b cnt %0d want 0001/0", {state, busy, irq_pend}, cnt); else pass_cnt++;
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    total_cnt++; if (state !== 2'b00 || busy !== 1'b0 || cnt !== 4'd0) $display("FAIL coll_run_start_stop: state %b busy %b cnt %0d want 00/0/0", state, busy, cnt); else pass_cnt++;
  endtask

  task automatic test_error();
    period = 4'd0; start = 1'b1;
    tick(); start = 1'b0;
    total_cnt++; if (sts !== 7'b0000001) $display("FAIL err_set: got %b want 0000001", sts); else pass_cnt++;
    tick();
    total_cnt++; if (sts !== 7'b0000001) $display("FAIL err_sticky: got %b want 0000001", sts); else pass_cnt++;
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    total_cnt++; if (sts !== 7'b0000000) $display("FAIL err_clr: got %b want 0000000", sts); else pass_cnt++;
  endtask

  task automatic test_full_period();
    period = 4'd15; cont = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      tick();
      total_cnt++; if (cnt !== W'(k % 16)) $display("FAIL full_cnt k=%0d: got %0d want %0d", k, cnt, k % 16); else pass_cnt++;
      total_cnt++; if (wrap !== (k == 16 || k == 32)) $display("FAIL full_wrap k=%0d: got %b want %b", k, wrap, (k == 16 || k == 32)); else pass_cnt++;
    end
    stop = 1'b1; tick(); stop = 1'b0;
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
  endtask

  task automatic test_async_reset();
    period = 4'd2; cont = 1'b1; irq_en = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    total_cnt++; if (cnt !== 4'd2 || irq_pend !== 1'b1) $display("FAIL arst_pre: cnt %0d pend %b want 2/1", cnt, irq_pend); else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    total_cnt++; if (sts !== 7'b0000000 || cnt !== 4'd0) $display("FAIL arst_immediate: sts %b cnt %0d want 0000000/0", sts, cnt); else pass_cnt++;
    #2 rst = 1'b1;
    tick(); tick(); tick();
    total_cnt++; if (sts !== 7'b0000000 || cnt !== 4'd0) $display("FAIL arst_quiet: sts %b cnt %0d want 0000000/0", sts, cnt); else pass_cnt++;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    total_cnt++; if (state !== 2'b01 || cnt !== 4'd1) $display("FAIL arst_restart: state %b cnt %0d want 01/1", state, cnt); else pass_cnt++;
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_oneshot();
    test_period_change();
    test_collisions();
    test_error();
    test_full_period();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
